// File: rtl/cb_cfg_pkg.sv
// Shared types and constants for the connection-box configuration loader.
package cb_cfg_pkg;

  localparam int CB_CFG_NBITS       = 112;
  localparam int CB_CFG_BITS_PER_CU = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/cb_cfg_loader_if.sv
// Bit-serial configuration handshake between a frame source and the loader.
interface cb_cfg_loader_if;

  logic cfg_start;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic cfg_done;
  logic cfg_err;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, cfg_done, cfg_err
  );

endinterface

// File: rtl/cb_cfg_shift.sv
// Shadow shift register (LSB-first frame, new bit at MSB) plus running parity.
module cb_cfg_shift
  import cb_cfg_pkg::*;
#(
  parameter int NBITS = CB_CFG_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             acc_en,
  input  logic             bit_in,
  output logic [NBITS-1:0] shadow,
  output logic             parity
);

  logic [NBITS-1:0] shadow_reg;
  logic [NBITS-1:0] shadow_next;
  logic             parity_reg;
  logic             parity_next;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_shadow
      if (gi == NBITS - 1) begin : g_top
        assign shadow_next[gi] = shift_en ? bit_in : shadow_reg[gi];
      end else begin : g_mid
        assign shadow_next[gi] = shift_en ? shadow_reg[gi+1] : shadow_reg[gi];
      end
    end
  endgenerate

  // The shadow is not cleared on restart: every data beat overwrites it anyway.
  always_comb begin
    parity_next = parity_reg;
    if (clr) begin
      parity_next = 1'b0;
    end else if (acc_en) begin
      parity_next = parity_reg ^ bit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      parity_reg <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      parity_reg <= parity_next;
    end
  end

  assign shadow = shadow_reg;
  assign parity = parity_reg;

endmodule

// File: rtl/cb_cfg_loader.sv
// Loads a serial configuration frame, checks even parity, and commits it
// atomically to the connection-box latch bus.
module cb_cfg_loader
  import cb_cfg_pkg::*;
#(
  parameter int NBITS = CB_CFG_NBITS,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  cb_cfg_loader_if.slave   cfg,
  output logic [NBITS-1:0] sram_latch_con_bits
);

  cfg_state_e       state_reg;
  cfg_state_e       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [NBITS-1:0] latch_reg;
  logic             done_reg;
  logic             done_next;
  logic             err_reg;
  logic             err_next;
  logic             commit;
  logic             clr;
  logic             shift_en;
  logic             acc_en;
  logic [NBITS-1:0] shadow;
  logic             parity;

  cb_cfg_shift #(
    .NBITS (NBITS)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .acc_en   (acc_en),
    .bit_in   (cfg.cfg_data),
    .shadow   (shadow),
    .parity   (parity)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    commit     = 1'b0;
    clr        = 1'b0;
    shift_en   = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          clr        = 1'b1;
          err_next   = 1'b0;
        end
      end
      SHIFT: begin
        // A restart wins over any beat presented in the same cycle.
        if (cfg.cfg_start) begin
          cnt_next = '0;
          clr      = 1'b1;
          err_next = 1'b0;
        end else if (cfg.cfg_valid) begin
          acc_en = 1'b1;
          if (cnt_reg == CNT_W'(NBITS)) begin
            state_next = CHECK;
          end else begin
            shift_en = 1'b1;
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (!parity) begin
          commit    = 1'b1;
          done_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      latch_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (commit) begin
        latch_reg <= shadow;
      end
    end
  end

  // Ready is a pure decode of the state register, so no input reaches an output.
  assign cfg.cfg_ready        = (state_reg == SHIFT);
  assign cfg.cfg_done         = done_reg;
  assign cfg.cfg_err          = err_reg;
  assign sram_latch_con_bits  = latch_reg;

endmodule
